// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM encoding, wait-counter
// width, and the MEM/WB bundle layout with its bubble value.
package mem_stage_pkg;

  localparam int CNT_W = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Fields carried from EX/MEM; also the shape of the request latch.
  typedef struct packed {
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        writedatasel;
    logic        halt;
    logic [15:0] read2data;
    logic [15:0] aluresult;
    logic [2:0]  writeregsel;
  } xmpr_t;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic [15:0] readdata;
    logic [15:0] aluresult;
    logic        regwrite;
    logic        writedatasel;
    logic        halt;
    logic        err;
    logic [2:0]  writeregsel;
  } mwpr_t;

  // A bubble writes nothing, does not halt and carries no data.
  localparam mwpr_t MWPR_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the memory stage (master) and the memory (slave).
//
// Handshake: the master raises exactly one of mem_rd / mem_wr together with
// mem_addr (and mem_wdata for writes) and holds all of them stable until the
// slave answers with a single-cycle mem_done pulse; mem_rdata is only valid in
// that cycle. mem_done may arrive in the same cycle the request first appears.
// The master may abandon a request (timeout or reset); the slave must then
// treat the access as cancelled. mem_done with no request is ignored.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_done;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_stage_mwpr_regs.sv
// MEM/WB pipeline register bank with a bubble-select input: when bubble is
// high the register loads the empty bundle instead of the incoming fields.
module mwpr_regs
  import mem_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  bubble,
  input  mwpr_t d,
  output mwpr_t q
);

  // Load either the next instruction's fields or a bubble every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= MWPR_BUBBLE;
    end else if (bubble) begin
      q <= MWPR_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores to a variable-latency data memory,
// freezes upstream while an access is outstanding, bubbles MEM/WB meanwhile,
// and turns misaligned accesses and memory timeouts into an error halt.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt_xmpr,
  input  logic          memread_xmpr,
  input  logic          memwrite_xmpr,
  input  logic          regwrite_xmpr,
  input  logic          writedatasel_xmpr,
  input  logic [15:0]   read2data_xmpr,
  input  logic [15:0]   aluresult_xmpr,
  input  logic [2:0]    writeregsel_xmpr,
  mem_stage_if.master   mem,
  output logic          stall_mem,
  output logic [15:0]   readdata_mwpr,
  output logic [15:0]   aluresult_mwpr,
  output logic          regwrite_mwpr,
  output logic          writedatasel_mwpr,
  output logic          halt_mwpr,
  output logic          err_mwpr,
  output logic [2:0]    writeregsel_mwpr,
  output logic [0:0]    fsm_state
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  xmpr_t            live;
  xmpr_t            held;
  xmpr_t            cur;
  logic             access;
  logic             misaligned;
  logic             valid;
  logic             done;
  logic             timeout;
  mwpr_t            mwpr_d;
  mwpr_t            mwpr_q;

  assign live = '{
    memread:      memread_xmpr,
    memwrite:     memwrite_xmpr,
    regwrite:     regwrite_xmpr,
    writedatasel: writedatasel_xmpr,
    halt:         halt_xmpr,
    read2data:    read2data_xmpr,
    aluresult:    aluresult_xmpr,
    writeregsel:  writeregsel_xmpr
  };

  // In WAIT everything comes from the latch so the request stays stable even
  // if the EX/MEM inputs move; only valid accesses are ever latched.
  assign cur        = (state == ST_WAIT) ? held : live;
  assign access     = cur.memread | cur.memwrite;
  assign misaligned = access & cur.aluresult[0];
  assign valid      = access & ~cur.aluresult[0];
  assign done       = valid & mem.mem_done;
  assign timeout    = (state == ST_WAIT) & ~mem.mem_done & (cnt == TIMEOUT_VAL);

  // Stall is Mealy: it drops in the cycle the access completes or times out,
  // so upstream advances on the same edge MEM/WB is loaded.
  assign stall_mem = valid & ~done & ~timeout;

  // A set write bit wins over a set read bit.
  assign mem.mem_rd    = valid & ~cur.memwrite;
  assign mem.mem_wr    = valid & cur.memwrite;
  assign mem.mem_addr  = cur.aluresult;
  assign mem.mem_wdata = cur.read2data;

  // Build the MEM/WB bundle for the instruction currently being resolved.
  always_comb begin
    mwpr_d              = MWPR_BUBBLE;
    mwpr_d.aluresult    = cur.aluresult;
    mwpr_d.writeregsel  = cur.writeregsel;
    mwpr_d.writedatasel = cur.writedatasel;
    mwpr_d.regwrite     = cur.regwrite;
    mwpr_d.halt         = cur.halt;
    if (misaligned | timeout) begin
      mwpr_d.regwrite = 1'b0;
      mwpr_d.halt     = 1'b1;
      mwpr_d.err      = 1'b1;
    end else if (done & ~cur.memwrite) begin
      mwpr_d.readdata = mem.mem_rdata;
    end
  end

  // FSM, wait counter and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      held  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (stall_mem) begin
            state <= ST_WAIT;
            cnt   <= CNT_ONE;
            held  <= live;
          end
        end
        default: begin
          if (done | timeout) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  mwpr_regs u_mwpr_regs (
    .clk    (clk),
    .rst    (rst),
    .bubble (stall_mem),
    .d      (mwpr_d),
    .q      (mwpr_q)
  );

  assign readdata_mwpr     = mwpr_q.readdata;
  assign aluresult_mwpr    = mwpr_q.aluresult;
  assign regwrite_mwpr     = mwpr_q.regwrite;
  assign writedatasel_mwpr = mwpr_q.writedatasel;
  assign halt_mwpr         = mwpr_q.halt;
  assign err_mwpr          = mwpr_q.err;
  assign writeregsel_mwpr  = mwpr_q.writeregsel;
  assign fsm_state         = state;

endmodule
